// File: rtl/led_blink_pkg.sv
// Shared definitions for the selectable-rate LED blinker.
//
// Contents:
//   SEL_F0..SEL_F3   encodings of {switch2, switch1} for the four blink rates
//   DEF_*            default clock and blink frequencies in Hz
//   half_count()     clocks per half period of a blink rate
//   cnt_width()      counter width needed to count 0..half-1 (never less than 1)
package led_blink_pkg;

  localparam logic [1:0] SEL_F0 = 2'b00;
  localparam logic [1:0] SEL_F1 = 2'b01;
  localparam logic [1:0] SEL_F2 = 2'b10;
  localparam logic [1:0] SEL_F3 = 2'b11;

  localparam int unsigned DEF_CLK_FREQ_HZ = 25000;
  localparam int unsigned DEF_FREQ_0_HZ   = 100;
  localparam int unsigned DEF_FREQ_1_HZ   = 50;
  localparam int unsigned DEF_FREQ_2_HZ   = 10;
  localparam int unsigned DEF_FREQ_3_HZ   = 1;

  // Integer division truncates. A zero rate yields 0 so the divider's range
  // check rejects it instead of dividing by zero.
  function automatic int unsigned half_count(input int unsigned clk_hz,
                                             input int unsigned freq_hz);
    if (freq_hz == 0) begin
      return 0;
    end
    return clk_hz / (2 * freq_hz);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned half);
    if (half <= 1) begin
      return 1;
    end
    return $clog2(half);
  endfunction

endpackage

// File: rtl/blink_divider.sv
// Free-running divide-by-(2*HALF_COUNT) square-wave generator.
//
// Ports:
//   clk     system clock, rising-edge active
//   rst_n   asynchronous active-low reset (counter and toggle cleared)
//   toggle  50 % duty square wave, period 2*HALF_COUNT clocks, starts low
module blink_divider
  import led_blink_pkg::*;
#(
  parameter int unsigned HALF_COUNT = 125
) (
  input  logic clk,
  input  logic rst_n,
  output logic toggle
);

  if (HALF_COUNT < 1) begin : g_half_check
    $error("blink_divider: HALF_COUNT must be at least 1");
  end

  localparam int unsigned CntW = cnt_width(HALF_COUNT);
  localparam logic [CntW-1:0] CntMax = CntW'(HALF_COUNT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            toggle_q, toggle_d;

  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    toggle_d = toggle_q;
    if (cnt_q == CntMax) begin
      cnt_d    = '0;
      toggle_d = ~toggle_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      toggle_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      toggle_q <= toggle_d;
    end
  end

  assign toggle = toggle_q;

endmodule

// File: rtl/led_blink.sv
// Selectable-rate LED blinker. Four free-running dividers produce square waves
// at FREQ_0..FREQ_3; {switch2, switch1} picks one, enable gates it, and the
// result is registered onto the LED pin.
//
// Ports:
//   clk      system clock, rising-edge active
//   rst_n    asynchronous active-low reset
//   enable   1 = blink at selected rate, 0 = LED off
//   switch1  rate select LSB
//   switch2  rate select MSB
//   led      registered LED drive, active high
module led_blink
  import led_blink_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int unsigned FREQ_0_HZ   = DEF_FREQ_0_HZ,
  parameter int unsigned FREQ_1_HZ   = DEF_FREQ_1_HZ,
  parameter int unsigned FREQ_2_HZ   = DEF_FREQ_2_HZ,
  parameter int unsigned FREQ_3_HZ   = DEF_FREQ_3_HZ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic switch1,
  input  logic switch2,
  output logic led
);

  localparam int unsigned Half0 = half_count(CLK_FREQ_HZ, FREQ_0_HZ);
  localparam int unsigned Half1 = half_count(CLK_FREQ_HZ, FREQ_1_HZ);
  localparam int unsigned Half2 = half_count(CLK_FREQ_HZ, FREQ_2_HZ);
  localparam int unsigned Half3 = half_count(CLK_FREQ_HZ, FREQ_3_HZ);

  // Dividers never see enable or the select, so switching rates or gating the
  // LED never disturbs their phase.
  logic [3:0] toggle;

  blink_divider #(.HALF_COUNT(Half0)) u_div0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .toggle (toggle[0])
  );

  blink_divider #(.HALF_COUNT(Half1)) u_div1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .toggle (toggle[1])
  );

  blink_divider #(.HALF_COUNT(Half2)) u_div2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .toggle (toggle[2])
  );

  blink_divider #(.HALF_COUNT(Half3)) u_div3 (
    .clk    (clk),
    .rst_n  (rst_n),
    .toggle (toggle[3])
  );

  logic [1:0] sel;
  logic       sel_toggle;
  logic       led_q, led_d;

  assign sel = {switch2, switch1};

  always_comb begin
    sel_toggle = 1'b0;
    unique case (sel)
      SEL_F0:  sel_toggle = toggle[0];
      SEL_F1:  sel_toggle = toggle[1];
      SEL_F2:  sel_toggle = toggle[2];
      SEL_F3:  sel_toggle = toggle[3];
      default: sel_toggle = 1'b0;
    endcase
    led_d = enable & sel_toggle;
  end

  // Registering the mux output keeps the pin glitch-free across select changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= 1'b0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_blink.sv
module tb_led_blink;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic switch1;
  logic switch2;
  logic led;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Rising edges since the last reset release.
  int unsigned k = 0;

  // Edge measurements of the observed led within a segment.
  logic        prev_led = 1'b0;
  int unsigned last_rise = 0;
  int unsigned meas_period = 0;
  int unsigned meas_high = 0;
  int unsigned first_rise = 0;
  int unsigned high_cycles = 0;

  led_blink dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .switch1 (switch1),
    .switch2 (switch2),
    .led     (led)
  );

  always #5 clk = ~clk;

  function automatic int unsigned half_of(input logic [1:0] s);
    case (s)
      2'b00:   return 125;
      2'b01:   return 250;
      2'b10:   return 1250;
      default: return 12500;
    endcase
  endfunction

  // Reference divider phase after n edges since release.
  function automatic logic tog_model(input logic [1:0] s, input int unsigned n);
    return logic'((n / half_of(s)) % 2);
  endfunction

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d (k=%0d)", tag, got, exp, k);
    end
  endtask

  task automatic seg_start();
    last_rise   = 0;
    meas_period = 0;
    meas_high   = 0;
    first_rise  = 0;
    high_cycles = 0;
  endtask

  // One clock: inputs seen at the edge are captured first, led checked #1 later.
  task automatic tick();
    logic       en_s;
    logic [1:0] sel_s;
    logic       rst_s;
    logic       exp_led;
    en_s  = enable;
    sel_s = {switch2, switch1};
    rst_s = rst_n;
    @(posedge clk);
    #1;
    if (!rst_s) begin
      k       = 0;
      exp_led = 1'b0;
    end else begin
      k++;
      exp_led = en_s & tog_model(sel_s, k - 1);
    end
    chk("led_cycle", 32'(led), 32'(exp_led));
    if (led) high_cycles++;
    if (led && !prev_led) begin
      if (last_rise != 0) meas_period = k - last_rise;
      if (first_rise == 0) first_rise = k;
      last_rise = k;
    end
    if (!led && prev_led && last_rise != 0) meas_high = k - last_rise;
    prev_led = led;
  endtask

  task automatic run(input int unsigned n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_sel(input logic [1:0] s);
    switch2 = s[1];
    switch1 = s[0];
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    set_sel(2'b00);

    // Reset held for three clocks.
    run(3);
    chk("reset_led", 32'(led), 0);
    chk("reset_toggles", 32'(dut.toggle), 0);
    rst_n = 1'b1;
    k     = 0;

    // 100 Hz: first rise at 126, then 250-clock period, 125 high.
    seg_start();
    run(5000);
    chk("first_rise_sel00", first_rise, 126);
    chk("period_sel00", meas_period, 250);
    chk("high_sel00", meas_high, 125);

    seg_start();
    set_sel(2'b01);
    run(5000);
    chk("period_sel01", meas_period, 500);
    chk("high_sel01", meas_high, 250);

    seg_start();
    set_sel(2'b10);
    run(12500);
    chk("period_sel10", meas_period, 2500);
    chk("high_sel10", meas_high, 1250);

    seg_start();
    set_sel(2'b11);
    run(50000);
    chk("period_sel11", meas_period, 25000);
    chk("high_sel11", meas_high, 12500);

    // Enable gating mid-run at 100 Hz; phase must survive.
    set_sel(2'b00);
    run(200);
    enable = 1'b0;
    seg_start();
    run(300);
    chk("disabled_high_cycles", high_cycles, 0);
    enable = 1'b1;
    seg_start();
    run(600);
    chk("period_after_enable", meas_period, 250);

    // Asynchronous reset between edges while led is high.
    begin
      int unsigned budget;
      budget = 0;
      while (!led && budget < 400) begin
        tick();
        budget++;
      end
      chk("wait_led_high", 32'(led), 1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_led", 32'(led), 0);
    chk("async_reset_toggles", 32'(dut.toggle), 0);
    run(3);
    chk("async_reset_held", 32'(led), 0);
    #2;
    rst_n = 1'b1;
    k     = 0;
    seg_start();
    run(1000);
    chk("first_rise_after_reset", first_rise, 126);
    chk("period_after_reset", meas_period, 250);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
